// File: rtl/umich_mult_seq_op.sv
//------------------------------------------------------------------------------
// umich_mult_seq_op
//
// Iterative shift-add multiplier returning the full 2*WIDTH-bit product of two
// WIDTH-bit operands. Each transaction selects unsigned or two's-complement
// operation. The multiplier retires BITS_PER_CYCLE multiplier bits per clock,
// so a product takes N = WIDTH / BITS_PER_CYCLE compute cycles. Only one
// transaction is in flight at a time.
//
// Operation outline:
//   - Signed operands are converted to unsigned magnitudes at accept.
//   - The magnitudes are multiplied unsigned.
//   - The result sign is applied once, on the completing edge.
//
// Ports:
//   clocked_on  rising-edge clock
//   clear_n     asynchronous active-low reset
//   flush       synchronous abort back to IDLE; Z is left untouched
//   tc          1 = two's-complement operands, 0 = unsigned (sampled at accept)
//   in_valid    A/B/tc valid
//   in_ready    operands can be accepted (combinational: IDLE and no flush)
//   A, B        multiplicand / multiplier, WIDTH bits
//   out_valid   Z holds a completed product
//   out_ready   consumer takes Z
//   Z           full 2*WIDTH-bit product
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module umich_mult_seq_op #(
  parameter int WIDTH          = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clocked_on,
  input  logic                 clear_n,
  input  logic                 flush,
  input  logic                 tc,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   Z
);

  localparam int W   = WIDTH;
  localparam int BPC = BITS_PER_CYCLE;
  localparam int N   = W / BPC;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("umich_mult_seq_op: WIDTH must be at least 2");
    end
    if (BPC != 1 && BPC != 2 && BPC != 4 && BPC != 8) begin : g_bad_bpc
      $error("umich_mult_seq_op: BITS_PER_CYCLE must be 1, 2, 4 or 8");
    end
    if (WIDTH % BPC != 0) begin : g_bad_ratio
      $error("umich_mult_seq_op: WIDTH must be a multiple of BITS_PER_CYCLE");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t          state;
  logic [W-1:0]    mag_a;     // |A|, held for the whole transaction
  logic            neg;       // product must be negated on completion
  logic [CW-1:0]   cnt;       // compute steps already retired
  // acc[2W-1:W] collects the partial-product sum. acc[W-1:0] starts as |B|.
  // As the sum shifts right into the low half, the multiplier bits are
  // consumed from the bottom. After N steps the whole register is |A|*|B|.
  logic [2*W-1:0]  acc;

  logic [W+BPC-1:0] partial;
  logic [W+BPC-1:0] sum;
  logic [2*W-1:0]   acc_step;

  // Two's-complement magnitude. Negating the most-negative value wraps back to
  // itself, which read as unsigned is exactly 2^(W-1).
  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v,
                                             input logic         is_tc);
    return (is_tc && v[W-1]) ? -v : v;
  endfunction

  assign in_ready = (state == IDLE) && !flush;

  // NOTE: combinational logic uses blocking assignments and writes every output
  // on every pass, so no storage is implied.
  always_comb begin
    partial = {{BPC{1'b0}}, mag_a} * {{W{1'b0}}, acc[BPC-1:0]};
    // Cannot carry out: the upper half never exceeds 2^W-1 and
    // partial <= (2^W-1)*(2^BPC-1).
    sum     = {{BPC{1'b0}}, acc[2*W-1:W]} + partial;
  end

  generate
    if (BPC == W) begin : g_single_step
      assign acc_step = sum;
    end else begin : g_multi_step
      assign acc_step = {sum, acc[W-1:BPC]};
    end
  endgenerate

  // NOTE: every register, datapath included, has a defined reset value.
  // Z and the accumulator must read 0 straight out of reset.
  always_ff @(posedge clocked_on or negedge clear_n) begin
    if (!clear_n) begin
      state     <= IDLE;
      mag_a     <= '0;
      neg       <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      Z         <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      // An abort outranks both accept and handoff.
      // Z stays as it was, but out_valid drops.
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge
      // values regardless of statement order.
      case (state)
        IDLE: begin
          if (in_valid) begin
            mag_a <= magnitude(A, tc);
            acc   <= {{W{1'b0}}, magnitude(B, tc)};
            neg   <= tc & (A[W-1] ^ B[W-1]);
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          acc <= acc_step;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            Z         <= neg ? -acc_step : acc_step;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_umich_mult_seq_op.sv
//------------------------------------------------------------------------------
// tb_umich_mult_seq_op
//
// Three instances of the multiplier:
//   cfg0: WIDTH=8,  BPC=1 (N=8)  - directed scenarios
//   cfg1: WIDTH=8,  BPC=8 (N=1)  - random operands and backpressure
//   cfg2: WIDTH=64, BPC=4 (N=16) - random operands and backpressure
//
// Every instance has a transaction-level model. The model tracks:
//   - whether a product is owed,
//   - how many edges have passed since accept,
//   - the last product that should be visible on Z.
// A per-instance monitor compares out_valid, in_ready and Z against the model
// on every falling edge.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_umich_mult_seq_op;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clear_n = 1'b0;
  int   n_vec   = 0;
  int   n_err   = 0;
  int   n_done  = 0;
  bit   mon_on  = 1'b0;
  bit   rnd_go  = 1'b0;

  task automatic check(input string name, input logic [127:0] got,
                       input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference product of w-bit operands, reduced mod 2^(2w). Signed operands
  // are sign-extended to 128 bits, so a plain 128-bit multiply is exact.
  function automatic logic [127:0] ref_mul(input int w, input bit t,
                                           input logic [63:0] a,
                                           input logic [63:0] b);
    logic [63:0]  m;
    logic [127:0] sa, sb, mask;
    m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    sa = {64'd0, a & m};
    sb = {64'd0, b & m};
    if (t && a[w-1]) sa = sa - (128'd1 << w);
    if (t && b[w-1]) sb = sb - (128'd1 << w);
    mask = (w == 64) ? '1 : ((128'd1 << (2 * w)) - 128'd1);
    return (sa * sb) & mask;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int W   = (g == 2) ? 64 : 8;
    localparam int BPC = (g == 0) ? 1 : ((g == 1) ? 8 : 4);
    localparam int N   = W / BPC;

    logic           flush     = 1'b0;
    logic           tc        = 1'b0;
    logic           in_valid  = 1'b0;
    logic           out_ready = 1'b1;
    logic [W-1:0]   a         = '0;
    logic [W-1:0]   b         = '0;
    logic           in_ready;
    logic           out_valid;
    logic [2*W-1:0] z;

    umich_mult_seq_op #(.WIDTH(W), .BITS_PER_CYCLE(BPC)) u_dut (
      .clocked_on (clk),
      .clear_n    (clear_n),
      .flush      (flush),
      .tc         (tc),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .A          (a),
      .B          (b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .Z          (z)
    );

    // Transaction model: a product is owed after an accept. It appears exactly
    // N edges later and stays until a handoff edge. Reset or flush drops it.
    bit           m_busy = 1'b0;
    int           m_age  = 0;
    logic [127:0] m_exp  = '0;
    logic [127:0] m_z    = '0;

    always @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
        m_busy <= 1'b0;
        m_z    <= '0;
      end else if (flush) begin
        m_busy <= 1'b0;
      end else if (!m_busy) begin
        if (in_valid) begin
          m_busy <= 1'b1;
          m_age  <= 0;
          m_exp  <= ref_mul(W, tc, 64'(a), 64'(b));
        end
      end else if (m_age == N) begin
        if (out_ready) m_busy <= 1'b0;
      end else begin
        m_age <= m_age + 1;
        if (m_age + 1 == N) m_z <= m_exp;
      end
    end

    always @(negedge clk) begin
      if (mon_on) begin
        check($sformatf("cfg%0d out_valid", g), 128'(out_valid),
              128'(m_busy && m_age == N));
        check($sformatf("cfg%0d in_ready", g), 128'(in_ready),
              128'(!m_busy && !flush));
        check($sformatf("cfg%0d Z", g), 128'(z), m_z);
      end
    end

    if (g == 0) begin : g_dir
      task automatic tick();
        @(posedge clk);
        #1;
      endtask

      // Present operands for one edge, then scramble them: the block must
      // ignore operand changes while busy.
      task automatic accept(input bit t, input logic [W-1:0] x,
                            input logic [W-1:0] y);
        tc = t; a = x; b = y; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; tc = ~t; a = ~x; b = y ^ 8'h5A;
      endtask

      task automatic wait_out(input string name, input logic [127:0] exp);
        int k = 0;
        while (out_valid !== 1'b1 && k < 4 * N + 8) begin
          tick();
          k++;
        end
        check({name, " latency"}, 128'(k), 128'(N));
        check({name, " Z"}, 128'(z), exp);
      endtask

      task automatic txn(input string name, input bit t, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [127:0] exp);
        accept(t, x, y);
        wait_out(name, exp);
        tick();
        check({name, " handoff out_valid"}, 128'(out_valid), 128'(0));
        check({name, " handoff in_ready"}, 128'(in_ready), 128'(1));
      endtask

      initial begin
        #2;
        check("reset out_valid", 128'(out_valid), 128'(0));
        check("reset Z", 128'(z), 128'(0));
        wait (mon_on);
        tick();
        check("idle in_ready", 128'(in_ready), 128'(1));

        // Basic unsigned and signed products.
        txn("u 200*100", 1'b0, 8'd200, 8'd100, 128'h4E20);
        txn("s -128*-128", 1'b1, 8'h80, 8'h80, 128'h4000);
        txn("s -3*5", 1'b1, 8'hFD, 8'h05, 128'hFFF1);
        txn("s -128*127", 1'b1, 8'h80, 8'h7F, 128'hC080);
        txn("s 0*-1", 1'b1, 8'h00, 8'hFF, 128'h0000);
        txn("u 255*255", 1'b0, 8'hFF, 8'hFF, 128'hFE01);

        // Backpressure: the product is held for five stalled cycles.
        out_ready = 1'b0;
        accept(1'b0, 8'd7, 8'd9);
        wait_out("bp 7*9", 128'd63);
        for (int i = 0; i < 5; i++) begin
          tick();
          check("bp held out_valid", 128'(out_valid), 128'(1));
          check("bp held Z", 128'(z), 128'd63);
          check("bp held in_ready", 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
        tick();
        check("bp release out_valid", 128'(out_valid), 128'(0));
        check("bp release in_ready", 128'(in_ready), 128'(1));

        // Flush on the third busy cycle; nothing may come out afterwards.
        accept(1'b0, 8'd11, 8'd13);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check("flush idle in_ready", 128'(in_ready), 128'(1));
        check("flush keeps Z", 128'(z), 128'd63);
        for (int i = 0; i < 12; i++) tick();
        // Flush with in_valid in IDLE: in_ready stays low and nothing is accepted.
        tc = 1'b0; a = 8'd3; b = 8'd3;
        flush = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
          #1;
          check("flush blocks in_ready", 128'(in_ready), 128'(0));
          tick();
        end
        flush = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        txn("post flush -7*6", 1'b1, 8'hF9, 8'h06, 128'hFFD6);

        // Asynchronous reset while busy.
        accept(1'b0, 8'd15, 8'd15);
        tick(); tick(); tick();
        clear_n = 1'b0;
        #1;
        check("busy reset out_valid", 128'(out_valid), 128'(0));
        check("busy reset Z", 128'(z), 128'(0));
        clear_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();

        // Asynchronous reset while holding a finished product.
        out_ready = 1'b0;
        accept(1'b0, 8'd9, 8'd9);
        wait_out("pre reset 9*9", 128'd81);
        tick();
        clear_n = 1'b0;
        #1;
        check("done reset out_valid", 128'(out_valid), 128'(0));
        check("done reset Z", 128'(z), 128'(0));
        clear_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();

        // Back-to-back transactions after the resets.
        txn("b2b -1*-1", 1'b1, 8'hFF, 8'hFF, 128'h0001);
        txn("b2b 255*255", 1'b0, 8'hFF, 8'hFF, 128'hFE01);
        txn("b2b -128*1", 1'b1, 8'h80, 8'h01, 128'hFF80);

        rnd_go = 1'b1;
        n_done++;
      end
    end else begin : g_rnd
      function automatic logic [W-1:0] pick();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 7))
          0:       return '0;
          1:       return '1;
          2:       return {1'b1, {(W-1){1'b0}}};
          3:       return {1'b0, {(W-1){1'b1}}};
          default: return r[W-1:0];
        endcase
      endfunction

      initial begin
        int sent = 0;
        int cyc  = 0;
        bit took;
        wait (rnd_go);
        @(posedge clk);
        #1;
        tc = 1'($urandom_range(0, 1)); a = pick(); b = pick();
        in_valid = 1'b1;
        while (sent < 1000 && cyc < 40000) begin
          @(negedge clk);
          took = in_valid && in_ready;
          @(posedge clk);
          #1;
          cyc++;
          if (took) begin
            sent++;
            tc = 1'($urandom_range(0, 1)); a = pick(); b = pick();
          end
          in_valid  = ($urandom_range(0, 7) != 0);
          out_ready = ($urandom_range(0, 3) != 0);
        end
        check($sformatf("cfg%0d transactions accepted", g), 128'(sent), 128'd1000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 2 * N + 4; i++) @(posedge clk);
        n_done++;
      end
    end
  end

  initial begin
    // Hand-computed values pin the reference model itself.
    check("model u8 200*100", ref_mul(8, 1'b0, 64'd200, 64'd100), 128'h4E20);
    check("model s8 -128*-128", ref_mul(8, 1'b1, 64'h80, 64'h80), 128'h4000);
    check("model s8 -3*5", ref_mul(8, 1'b1, 64'hFD, 64'h05), 128'hFFF1);
    check("model u64 max*max", ref_mul(64, 1'b0, '1, '1),
          128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    check("model s64 min*min",
          ref_mul(64, 1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000),
          128'h4000_0000_0000_0000_0000_0000_0000_0000);
    check("model s64 -1*-1", ref_mul(64, 1'b1, '1, '1), 128'h1);

    #12;
    clear_n = 1'b1;
    mon_on  = 1'b1;

    for (int c = 0; c < 60000 && n_done < 3; c++) @(posedge clk);
    check("all streams finished", 128'(n_done), 128'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
